// File: rtl/regwrite_scheduler.sv
// ---------------------------------------------------------------------------
// regwrite_scheduler
//
// Owns the single synchronous write port of the 32x32 MIPS register file and
// shares it between the in-order pipeline writeback (WB) and the long-latency
// multiply/divide unit (MD). WB always wins the port. MD cannot wait forever:
// an age counter requests a one-cycle WB bubble through pipe_hold.
//
// A busy scoreboard tracks the destination of every MD operation still in
// flight. Decode uses it for two things: raw_stall (a source register is still
// being computed) and iss_ready (a new MD op may be issued). Writing a busy
// register from WB sets the sticky waw_err flag.
//
// Ports
//   Clk, Reset_n            clock (posedge) and asynchronous active-low reset
//   wb_valid/reg/data       pipeline writeback, cannot be back-pressured
//   md_valid/reg/data       MD result, held stable until md_ready
//   md_ready                MD result accepted this cycle (combinational)
//   iss_valid/iss_reg       decode wants to issue an MD op to iss_reg
//   iss_ready               MD issue accepted this cycle (combinational)
//   rs, rt                  decode source registers
//   raw_stall               a decode source is still busy (combinational)
//   pipe_hold               registered; pipeline must drop wb_valid next cycle
//   RegWrite/WriteRegister/WriteData  registered register-file write port
//   waw_err                 sticky: WB wrote a register owned by MD
// ---------------------------------------------------------------------------
module regwrite_scheduler #(
  parameter int unsigned STARVE_LIMIT = 4,  // 1..15
  parameter int unsigned MAX_PEND     = 4   // 1..31
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        md_valid,
  input  logic [4:0]  md_reg,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_reg,
  output logic        iss_ready,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  output logic        raw_stall,
  output logic        pipe_hold,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic        waw_err
);

  localparam logic [4:0] MAX_PEND_C = 5'(MAX_PEND);
  localparam logic [3:0] AGE_LAST_C = 4'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_HOLD   = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // One-hot decode of a register index into a 32-bit scoreboard mask.
  function automatic logic [31:0] reg_mask(input logic [4:0] idx);
    reg_mask = 32'd1 << idx;
  endfunction

  state_t      state_r;
  logic [3:0]  age_r;
  logic [31:0] busy_r;
  logic [4:0]  pend_cnt_r;

  logic        md_blocked_s;
  logic        sb_set_s;
  logic        sb_clr_s;
  logic [31:0] busy_nxt_s;
  logic [4:0]  pend_nxt_s;
  logic        wr_en_s;
  logic        wr_upd_s;
  logic [4:0]  wr_addr_s;
  logic [31:0] wr_data_s;
  logic        waw_hit_s;

  // Port arbitration, issue acceptance and the decode RAW check.
  always_comb begin
    md_ready     = md_valid & ~wb_valid;
    md_blocked_s = md_valid & ~md_ready;
    iss_ready    = iss_valid
                 & ((iss_reg == 5'd0) | ~busy_r[iss_reg])
                 & (pend_cnt_r < MAX_PEND_C);
    raw_stall    = ((rs != 5'd0) & busy_r[rs]) | ((rt != 5'd0) & busy_r[rt]);
    waw_hit_s    = wb_valid & (wb_reg != 5'd0) & busy_r[wb_reg];
  end

  // Scoreboard next state. A set and a clear can never hit the same register
  // in one cycle because iss_ready refuses registers that are already busy.
  always_comb begin
    sb_set_s   = iss_ready & (iss_reg != 5'd0);
    sb_clr_s   = md_ready & (md_reg != 5'd0) & busy_r[md_reg];
    busy_nxt_s = busy_r;
    if (sb_clr_s) begin
      busy_nxt_s = busy_nxt_s & ~reg_mask(md_reg);
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (sb_set_s) begin
      busy_nxt_s = busy_nxt_s | reg_mask(iss_reg);
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    busy_nxt_s[0] = 1'b0;
    case ({sb_set_s, sb_clr_s})
      2'b10:   pend_nxt_s = pend_cnt_r + 5'd1;
      2'b01:   pend_nxt_s = pend_cnt_r - 5'd1;
      default: pend_nxt_s = pend_cnt_r;
    endcase
  end

  // Write-port selection. A winner targeting r0 is consumed but produces no
  // register-file write, and address/data keep their previous values.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_upd_s  = 1'b0;
    wr_addr_s = wb_reg;
    wr_data_s = wb_data;
    if (wb_valid) begin
      wr_upd_s  = 1'b1;
      wr_addr_s = wb_reg;
      wr_data_s = wb_data;
      wr_en_s   = (wb_reg != 5'd0);
    end else if (md_ready) begin
      wr_upd_s  = 1'b1;
      wr_addr_s = md_reg;
      wr_data_s = md_data;
      wr_en_s   = (md_reg != 5'd0);
    end else begin
      wr_upd_s  = 1'b0;
      wr_en_s   = 1'b0;
    end
  end

  // Registered register-file write port.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      RegWrite      <= 1'b0;
      WriteRegister <= 5'd0;
      WriteData     <= 32'd0;
    end else begin
      RegWrite <= wr_en_s;
      if (wr_upd_s && wr_en_s) begin
        WriteRegister <= wr_addr_s;
        WriteData     <= wr_data_s;
      end else begin
        WriteRegister <= WriteRegister;
        WriteData     <= WriteData;
      end
    end
  end

  // Busy scoreboard and its population count.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      busy_r     <= 32'd0;
      pend_cnt_r <= 5'd0;
    end else begin
      busy_r     <= busy_nxt_s;
      pend_cnt_r <= pend_nxt_s;
    end
  end

  // Sticky WAW flag; the offending write still goes through.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      waw_err <= 1'b0;
    end else if (waw_hit_s) begin
      waw_err <= 1'b1;
    end else begin
      waw_err <= waw_err;
    end
  end

  // Starvation FSM: after STARVE_LIMIT consecutive blocked MD cycles, hold the
  // pipeline for one cycle so that the following cycle (DRAIN) is WB-free.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r   <= ST_NORMAL;
      age_r     <= 4'd0;
      pipe_hold <= 1'b0;
    end else begin
      case (state_r)
        ST_NORMAL: begin
          if (md_blocked_s) begin
            if (age_r == AGE_LAST_C) begin
              state_r   <= ST_HOLD;
              age_r     <= 4'd0;
              pipe_hold <= 1'b1;
            end else begin
              state_r   <= ST_NORMAL;
              age_r     <= age_r + 4'd1;
              pipe_hold <= 1'b0;
            end
          end else begin
            state_r   <= ST_NORMAL;
            age_r     <= 4'd0;
            pipe_hold <= 1'b0;
          end
        end
        ST_HOLD: begin
          state_r   <= ST_DRAIN;
          age_r     <= 4'd0;
          pipe_hold <= 1'b0;
        end
        ST_DRAIN: begin
          state_r   <= ST_NORMAL;
          age_r     <= 4'd0;
          pipe_hold <= 1'b0;
        end
        default: begin
          state_r   <= ST_NORMAL;
          age_r     <= 4'd0;
          pipe_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regwrite_scheduler.sv
// ---------------------------------------------------------------------------
// tb_regwrite_scheduler
//
// Directed scenarios with literal expectations, plus a reference model that
// keeps the scoreboard as a plain array and the starvation rule as a streak
// counter; a negedge process compares every DUT output with the model.
// ---------------------------------------------------------------------------
module tb_regwrite_scheduler;

  localparam int STARVE_LIMIT = 4;
  localparam int MAX_PEND     = 4;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_ready;
  logic        iss_valid;
  logic [4:0]  iss_reg;
  logic        iss_ready;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        raw_stall;
  logic        pipe_hold;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        waw_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit run     = 1'b0;

  regwrite_scheduler #(.STARVE_LIMIT(STARVE_LIMIT), .MAX_PEND(MAX_PEND)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
    .iss_valid(iss_valid), .iss_reg(iss_reg), .iss_ready(iss_ready),
    .rs(rs), .rt(rt), .raw_stall(raw_stall), .pipe_hold(pipe_hold),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .waw_err(waw_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_busy [32];
  bit          m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  bit          m_waw;
  bit          m_hold;
  int          m_streak;  // consecutive blocked MD cycles
  int          m_quiet;   // remaining hold/drain cycles after a trigger

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0;
    m_waw = 1'b0; m_hold = 1'b0; m_streak = 0; m_quiet = 0;
  endtask

  function automatic int pending();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic bit exp_md_ready();
    return md_valid && !wb_valid;
  endfunction

  function automatic bit exp_iss_ready();
    return iss_valid && (iss_reg == 5'd0 || !m_busy[iss_reg]) && (pending() < MAX_PEND);
  endfunction

  function automatic bit exp_raw();
    return (rs != 5'd0 && m_busy[rs]) || (rt != 5'd0 && m_busy[rt]);
  endfunction

  task automatic model_step();
    bit acc_md, acc_iss;
    acc_md  = exp_md_ready();
    acc_iss = exp_iss_ready();
    if (wb_valid) begin
      m_we = (wb_reg != 5'd0);
      if (wb_reg != 5'd0) begin m_wa = wb_reg; m_wd = wb_data; end
    end else if (acc_md) begin
      m_we = (md_reg != 5'd0);
      if (md_reg != 5'd0) begin m_wa = md_reg; m_wd = md_data; end
    end else begin
      m_we = 1'b0;
    end
    if (wb_valid && wb_reg != 5'd0 && m_busy[wb_reg]) m_waw = 1'b1;
    if (acc_md && md_reg != 5'd0) m_busy[md_reg] = 1'b0;
    if (acc_iss && iss_reg != 5'd0) m_busy[iss_reg] = 1'b1;
    if (m_quiet > 0) begin
      m_quiet--;
      m_streak = 0;
    end else if (md_valid && !acc_md) begin
      m_streak++;
      if (m_streak == STARVE_LIMIT) begin
        m_quiet  = 2;
        m_streak = 0;
      end
    end else begin
      m_streak = 0;
    end
    m_hold = (m_quiet == 2);
  endtask

  // Compare every output with the model mid-cycle, then advance the model.
  always @(negedge Clk) begin
    if (!Reset_n) begin
      model_reset();
    end else if (run) begin
      chk("md_ready",      32'(md_ready),      32'(exp_md_ready()));
      chk("iss_ready",     32'(iss_ready),     32'(exp_iss_ready()));
      chk("raw_stall",     32'(raw_stall),     32'(exp_raw()));
      chk("pipe_hold",     32'(pipe_hold),     32'(m_hold));
      chk("RegWrite",      32'(RegWrite),      32'(m_we));
      chk("WriteRegister", 32'(WriteRegister), 32'(m_wa));
      chk("WriteData",     WriteData,          m_wd);
      chk("waw_err",       32'(waw_err),       32'(m_waw));
      model_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    wb_valid = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
    md_valid = 1'b0; md_reg = 5'd0; md_data = 32'd0;
    iss_valid = 1'b0; iss_reg = 5'd0; rs = 5'd0; rt = 5'd0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_md(input logic [4:0] r, input logic [31:0] d);
    md_valid = 1'b1; md_reg = r; md_data = d;
    tick();
    md_valid = 1'b0;
  endtask

  task automatic do_iss(input logic [4:0] r);
    iss_valid = 1'b1; iss_reg = r;
    tick();
    iss_valid = 1'b0;
  endtask

  initial begin
    // Reset with every input active.
    Reset_n = 1'b0;
    wb_valid = 1'b1; wb_reg = 5'd6; wb_data = 32'h1111_2222;
    md_valid = 1'b1; md_reg = 5'd7; md_data = 32'h3333_4444;
    iss_valid = 1'b1; iss_reg = 5'd5; rs = 5'd5; rt = 5'd7;
    #12;
    chk("rst_RegWrite",  32'(RegWrite),  32'd0);
    chk("rst_iss_ready", 32'(iss_ready), 32'd1);
    chk("rst_raw_stall", 32'(raw_stall), 32'd0);
    chk("rst_pipe_hold", 32'(pipe_hold), 32'd0);
    chk("rst_WriteReg",  32'(WriteRegister), 32'd0);
    @(posedge Clk); #1;
    idle();
    wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'hDEAD_BEEF;
    Reset_n = 1'b1;
    run = 1'b1;
    tick();
    idle();
    chk("wb_first_we",   32'(RegWrite), 32'd1);
    chk("wb_first_addr", 32'(WriteRegister), 32'd3);
    chk("wb_first_data", WriteData, 32'hDEAD_BEEF);

    // Issue to r8, RAW stall, MD completes.
    iss_valid = 1'b1; iss_reg = 5'd8; #1;
    chk("iss8_ready", 32'(iss_ready), 32'd1);
    tick();
    iss_valid = 1'b0; rs = 5'd8; #1;
    chk("raw8", 32'(raw_stall), 32'd1);
    md_valid = 1'b1; md_reg = 5'd8; md_data = 32'h0000_1234; #1;
    chk("md8_ready", 32'(md_ready), 32'd1);
    tick();
    md_valid = 1'b0; #1;
    chk("md8_addr", 32'(WriteRegister), 32'd8);
    chk("md8_data", WriteData, 32'h0000_1234);
    chk("raw8_clear", 32'(raw_stall), 32'd0);
    rs = 5'd0;

    // WB/MD collision.
    wb_valid = 1'b1; wb_reg = 5'd4; wb_data = 32'h0000_000A;
    md_valid = 1'b1; md_reg = 5'd9; md_data = 32'h0000_000B; #1;
    chk("coll_md_ready", 32'(md_ready), 32'd0);
    tick();
    wb_valid = 1'b0; #1;
    chk("coll_wb_addr", 32'(WriteRegister), 32'd4);
    chk("coll_wb_data", WriteData, 32'h0000_000A);
    chk("coll_md_ready2", 32'(md_ready), 32'd1);
    tick();
    md_valid = 1'b0;
    chk("coll_md_addr", 32'(WriteRegister), 32'd9);
    chk("coll_md_data", WriteData, 32'h0000_000B);

    // Starvation: MD blocked by continuous WB.
    wb_valid = 1'b1; wb_reg = 5'd1; wb_data = 32'h0000_0100;
    md_valid = 1'b1; md_reg = 5'd2; md_data = 32'h0000_0077;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("starve_hold", 32'(pipe_hold), 32'(i == 4));
    end
    wb_valid = 1'b0; #1;
    chk("starve_md_ready", 32'(md_ready), 32'd1);
    tick();
    md_valid = 1'b0;
    chk("drain_hold", 32'(pipe_hold), 32'd0);
    chk("drain_addr", 32'(WriteRegister), 32'd2);
    chk("drain_data", WriteData, 32'h0000_0077);
    tick();
    tick();
    chk("normal_hold", 32'(pipe_hold), 32'd0);

    // Scoreboard capacity and busy re-issue.
    do_iss(5'd10); do_iss(5'd11); do_iss(5'd13); do_iss(5'd14);
    iss_valid = 1'b1; iss_reg = 5'd15; #1;
    chk("full_iss_ready", 32'(iss_ready), 32'd0);
    iss_valid = 1'b0;
    do_md(5'd11, 32'h0000_0011);
    iss_valid = 1'b1; iss_reg = 5'd10; #1;
    chk("busy_reissue", 32'(iss_ready), 32'd0);
    iss_reg = 5'd15; #1;
    chk("fifth_iss_ready", 32'(iss_ready), 32'd1);
    tick();
    iss_valid = 1'b0;
    do_md(5'd10, 32'h0000_0010); do_md(5'd13, 32'h0000_0013);
    do_md(5'd14, 32'h0000_0014); do_md(5'd15, 32'h0000_0015);

    // WAW, and writes to r0.
    do_iss(5'd12);
    wb_valid = 1'b1; wb_reg = 5'd12; wb_data = 32'h0000_0055;
    tick();
    wb_valid = 1'b0;
    chk("waw_set", 32'(waw_err), 32'd1);
    chk("waw_write", 32'(RegWrite), 32'd1);
    tick(); tick();
    chk("waw_sticky", 32'(waw_err), 32'd1);
    wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'h0000_0099;
    tick();
    wb_valid = 1'b0;
    chk("wb_r0_we", 32'(RegWrite), 32'd0);
    md_valid = 1'b1; md_reg = 5'd0; md_data = 32'h0000_0088; #1;
    chk("md_r0_ready", 32'(md_ready), 32'd1);
    tick();
    md_valid = 1'b0;
    chk("md_r0_we", 32'(RegWrite), 32'd0);
    do_md(5'd12, 32'h0000_0012);

    // Set and clear of different registers in the same cycle.
    do_iss(5'd21);
    iss_valid = 1'b1; iss_reg = 5'd20;
    md_valid = 1'b1; md_reg = 5'd21; md_data = 32'h0000_0021;
    tick();
    iss_valid = 1'b0; md_valid = 1'b0;
    rs = 5'd20; rt = 5'd21; #1;
    chk("setclr_raw", 32'(raw_stall), 32'd1);
    rs = 5'd0; #1;
    chk("setclr_rt_free", 32'(raw_stall), 32'd0);
    rt = 5'd0;
    do_md(5'd20, 32'h0000_0020);

    // Asynchronous reset in the middle of traffic.
    do_iss(5'd7);
    wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'h0000_0505;
    tick();
    wb_valid = 1'b0; rs = 5'd7;
    chk("pre_rst_we", 32'(RegWrite), 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_we", 32'(RegWrite), 32'd0);
    chk("async_rst_raw", 32'(raw_stall), 32'd0);
    chk("async_rst_waw", 32'(waw_err), 32'd0);
    @(posedge Clk); #1;
    idle();
    Reset_n = 1'b1;

    // Pseudo-random traffic under the pipeline contract; model checks it.
    for (int c = 0; c < 400; c++) begin
      wb_valid = (pipe_hold == 1'b1) ? 1'b0 : ($urandom_range(0, 2) == 0);
      wb_reg   = 5'($urandom_range(0, 9));
      wb_data  = $urandom;
      if (!md_valid) begin
        md_valid = ($urandom_range(0, 1) == 1);
        md_reg   = 5'($urandom_range(0, 9));
        md_data  = $urandom;
      end
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_reg   = 5'($urandom_range(0, 9));
      rs        = 5'($urandom_range(0, 9));
      rt        = 5'($urandom_range(0, 9));
      #1;
      if (md_valid && !wb_valid) begin
        tick();
        md_valid = 1'b0;
      end else begin
        tick();
      end
    end

    idle();
    tick();
    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regwrite_scheduler.md
Name: regwrite_scheduler

Overview:
- Owns the single synchronous write port of the 32x32 MIPS register file.
- Arbitrates that port between the in-order pipeline writeback (WB) and the long-latency multiply/divide unit (MD).
- Keeps a per-register busy scoreboard for MD destinations and raises read-after-write and issue stalls to the decode stage.
- Prevents MD starvation with an age counter that forces a one-cycle WB bubble.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles MD may wait before a forced WB bubble is requested (1..15).
- MAX_PEND, 4, maximum number of MD destinations that may be outstanding in the scoreboard (1..31).

Ports:
- Clk  in  1  clock, all state updates on posedge.
- Reset_n  in  1  asynchronous active-low reset.
- wb_valid  in  1  pipeline writeback present this cycle; cannot be back-pressured.
- wb_reg  in  5  WB destination register.
- wb_data  in  32  WB data.
- md_valid  in  1  MD result offered; held stable until accepted.
- md_reg  in  5  MD destination register.
- md_data  in  32  MD result.
- md_ready  out  1  MD result accepted this cycle.
- iss_valid  in  1  decode wants to issue an MD op.
- iss_reg  in  5  MD op destination register.
- iss_ready  out  1  MD issue accepted this cycle.
- rs  in  5  decode source register A.
- rt  in  5  decode source register B.
- raw_stall  out  1  decode must stall because a source is busy.
- pipe_hold  out  1  pipeline must present wb_valid=0 on the next cycle.
- RegWrite  out  1  registered write enable to the register file.
- WriteRegister  out  5  registered write address.
- WriteData  out  32  registered write data.
- waw_err  out  1  sticky error flag.

Behaviour:
- Reset (async, Reset_n=0):
  - busy=0, pend_cnt=0, age=0, state=NORMAL.
  - RegWrite=0, WriteRegister=0, WriteData=0, pipe_hold=0, waw_err=0.
  - All combinational outputs then follow from this state.
- Arbitration (combinational):
  - WB always wins.
  - md_ready = md_valid & !wb_valid.
- Write port (registered, latency 1 cycle):
  - If wb_valid: next {RegWrite,WriteRegister,WriteData} = {1,wb_reg,wb_data}.
  - Else if md_ready: next = {1,md_reg,md_data}.
  - Else RegWrite=0 and address/data hold their previous values.
  - Register 0 as destination: the write is accepted (md_ready still asserts) but RegWrite=0 is emitted.
- Scoreboard:
  - busy[31:0], busy[0] always 0.
  - pend_cnt is 0..MAX_PEND and equals popcount(busy).
  - iss_ready = iss_valid & (iss_reg==0 | !busy[iss_reg]) & pend_cnt<MAX_PEND.
  - Issue to register 0: accepted, nothing is set.
  - On iss_ready with iss_reg!=0: set busy[iss_reg], pend_cnt+1.
  - On md_ready with md_reg!=0 and busy[md_reg]: clear busy[md_reg], pend_cnt-1.
  - Set and clear in the same cycle on different registers: both take effect, pend_cnt unchanged.
  - The same register cannot be set and cleared in the same cycle, because iss_ready is evaluated on current busy.
- RAW stall (combinational): raw_stall = (rs!=0 & busy[rs]) | (rt!=0 & busy[rt]).
- WAW check:
  - wb_valid & wb_reg!=0 & busy[wb_reg] sets waw_err (sticky until reset).
  - The write still proceeds.
- Starvation FSM:
  - States:
    - NORMAL: age counts cycles with md_valid & !md_ready.
    - HOLD: pipe_hold=1 for exactly one cycle.
    - DRAIN: the pipeline guarantees wb_valid=0, so MD is accepted.
  - Transitions:
    - age reset to 0 whenever md_ready=1 or md_valid=0.
    - NORMAL->HOLD when age reaches STARVE_LIMIT-1 and MD is again blocked.
    - HOLD->DRAIN unconditionally.
    - DRAIN->NORMAL unconditionally, age=0.
  - pipe_hold is a registered output, high only in HOLD.
  - If wb_valid is seen in DRAIN (pipeline contract violation), WB still wins and waw_err is not affected.
- Reset mid-operation: all pending scoreboard state is discarded and the write-port enable drops immediately (async).

Test Plan:
- Reset with all inputs active -> RegWrite=0, iss_ready=1 for iss_reg=5, raw_stall=0. After the Reset_n rise, wb_valid=1, wb_reg=3, wb_data=0xDEADBEEF -> next cycle RegWrite=1, WriteRegister=3, WriteData=0xDEADBEEF.
- Issue iss_reg=8 -> rs=8 gives raw_stall=1. md_valid with md_reg=8, md_data=0x1234 and no WB -> md_ready=1, next cycle write (8,0x1234), then raw_stall=0 and pend_cnt=0.
- Same-cycle collision: wb_valid(4,0xA) and md_valid(9,0xB) -> cycle 1 writes reg4 with md_ready=0. Next cycle with WB idle -> reg9 written with 0xB.
- wb_valid held high with md_valid high, STARVE_LIMIT=4 -> pipe_hold=1 for exactly one cycle after 4 blocked cycles. Then with wb_valid=0, MD is accepted and the FSM returns to NORMAL.
- Issue 4 distinct registers (MAX_PEND=4), then a 5th -> iss_ready=0. Re-issuing an already-busy register -> iss_ready=0. Completing one -> 5th accepted next cycle.
- Issue 12, then WB to reg12 -> waw_err=1 and stays set. WB to reg0 -> RegWrite=0. MD to reg0 -> md_ready=1, RegWrite=0.
